// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes rx, samples start/data/parity/stop at mid-bit.
// Optional build macro RX_MAJORITY_EN: each sample point is a 2-of-3 vote one tick later.
module uart_rx_deserializer #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 parity_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_bit_out,
  output logic                 data_valid,
  output logic                 framing_error,
  output logic                 busy
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE + 1);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF   = OVERSAMPLE / 2;
`ifdef RX_MAJORITY_EN
  localparam int unsigned START_LAST = HALF;
`else
  localparam int unsigned START_LAST = HALF - 1;
`endif
  localparam int unsigned BIT_LAST = OVERSAMPLE - 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 par_en_q, par_en_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_out_q, par_out_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;
  logic                 smp;
  logic                 start_pt;
  logic                 bit_pt;

  assign rx_s = sync_q[1];

`ifdef RX_MAJORITY_EN
  // rx history at the two previous ticks; vote is taken on the tick after the nominal sample
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else if (baud_tick) begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign smp = rx_s;
`endif

  assign start_pt = baud_tick && (tick_cnt_q == TICK_W'(START_LAST));
  assign bit_pt   = baud_tick && (tick_cnt_q == TICK_W'(BIT_LAST));

  // Next-state and datapath decode
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    par_en_d   = par_en_q;
    data_d     = data_q;
    par_out_d  = par_out_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;

    if (baud_tick) begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (baud_tick && !rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
          par_en_d   = parity_en;
          par_d      = 1'b0;
        end
      end
      START: begin
        if (start_pt) begin
          tick_cnt_d = '0;
          if (!smp) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_pt) begin
          tick_cnt_d = '0;
          shift_d    = {smp, shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_pt) begin
          tick_cnt_d = '0;
          par_d      = smp;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_pt) begin
          tick_cnt_d = '0;
          data_d     = shift_q;
          par_out_d  = par_en_q & par_q;
          valid_d    = 1'b1;
          ferr_d     = !smp;
          state_d    = smp ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        // a held-low line (break) must go high before a new start is accepted
        if (baud_tick && rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      par_en_q   <= 1'b0;
      data_q     <= '0;
      par_out_q  <= 1'b0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], rx};
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      par_en_q   <= par_en_d;
      data_q     <= data_d;
      par_out_q  <= par_out_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out       = data_q;
  assign parity_bit_out = par_out_q;
  assign data_valid     = valid_q;
  assign framing_error  = ferr_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: serial frames driven on rx, results checked at data_valid.
`timescale 1ns/1ps
module tb_uart_rx_deserializer;

  localparam int OS = 16;
  localparam int DB = 8;
`ifdef RX_MAJORITY_EN
  localparam int MAJ_LAT = 1;
`else
  localparam int MAJ_LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_tick;
  logic          rx;
  logic          parity_en;
  logic [DB-1:0] data_out;
  logic          parity_bit_out;
  logic          data_valid;
  logic          framing_error;
  logic          busy;

  uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk            (clk),
    .rst            (rst),
    .baud_tick      (baud_tick),
    .rx             (rx),
    .parity_en      (parity_en),
    .data_out       (data_out),
    .parity_bit_out (parity_bit_out),
    .data_valid     (data_valid),
    .framing_error  (framing_error),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec = 0;
  int misc = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vec++;
    if (act !== exp_v) begin
      misc++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  // Baud tick generator: one tick every div clocks
  int div = 1;
  int tphase = 0;
  always @(negedge clk) begin
    baud_tick = (tphase == 0);
    tphase    = (tphase + 1 >= div) ? 0 : tphase + 1;
  end

  // Expected frame results, derived from what was put on the line
  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       ferr;
    int         vcyc;
  } exp_t;
  exp_t exp_q[$];

  // Monitor: pops one expectation per data_valid pulse
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (data_valid) begin
        chk("valid_single_pulse", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          vec++;
          misc++;
          $display("FAIL unexpected_valid: data_valid=1 data_out=%0h, expected no frame (cycle %0d)",
                   data_out, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", 32'(data_out), 32'(e.data));
          chk("parity_bit_out", 32'(parity_bit_out), 32'(e.par));
          chk("framing_error", 32'(framing_error), 32'(e.ferr));
          if (e.vcyc >= 0) chk("valid_cycle", 32'(cyc), 32'(e.vcyc));
        end
      end else if (framing_error) begin
        chk("ferr_without_valid", 32'(framing_error), 32'd0);
      end
      prev_valid = data_valid;
    end
  end

  // Hold rx at v for one bit period; optional one-clock inversion at the sample point (div=1)
  task automatic drive_bit(input logic v, input bit glitch);
    rx = v;
    if (glitch) begin
      repeat (OS / 2) @(negedge clk);
      rx = ~v;
      @(negedge clk);
      rx = v;
      repeat (OS / 2 - 1) @(negedge clk);
    end else begin
      repeat (OS * div) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic stop, input bit toggle, input int gbit);
    exp_t e;
    parity_en = pe;
    e.data = d;
    e.par  = pe & pb;
    e.ferr = ~stop;
    // start edge seen after 2 sync flops + 1 clk; stop sample mid-bit; valid one clk later
    e.vcyc = (div == 1) ? cyc + 3 + OS / 2 + OS * (DB + 1 + int'(pe)) + MAJ_LAT : -1;
    exp_q.push_back(e);
    drive_bit(1'b0, 1'b0);
    if (toggle) parity_en = ~pe;
    for (int i = 0; i < DB; i++) drive_bit(d[i], (i == gbit));
    if (pe) drive_bit(pb, 1'b0);
    drive_bit(stop, 1'b0);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    int n;
    logic [7:0] d;
    logic pe, pb, st;
    bit tg;

    rst = 1'b1;
    rx = 1'b1;
    parity_en = 1'b0;
    baud_tick = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_parity", 32'(parity_bit_out), 32'd0);
    chk("reset_valid", 32'(data_valid), 32'd0);
    chk("reset_ferr", 32'(framing_error), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (OS) @(negedge clk);

    // 0xA5, no parity, tick every clk
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    drive_bit(1'b1, 1'b0);

    // 0x3C with parity bit 1, parity_en toggled mid-frame
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, -1);
    drive_bit(1'b1, 1'b0);

    // start glitch of 4 ticks: false start, back to idle at the start sample
    n = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    chk("glitch_busy_high", 32'(busy), 32'd1);
    wait_cyc(n + 3 + OS / 2 + MAJ_LAT);
    chk("glitch_busy_low", 32'(busy), 32'd0);
    repeat (2 * OS) @(negedge clk);

    // 0x55 with stop=0 then line held low (break)
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    repeat (50) @(negedge clk);
    chk("break_busy_held", 32'(busy), 32'd1);
    chk("break_data_hold", 32'(data_out), 32'h55);
    rx = 1'b1;
    repeat (OS) @(negedge clk);
    chk("break_released", 32'(busy), 32'd0);

    // reset during data bit 3, then 0x81
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1 & (i == 0), 1'b0);
    rx = 1'b0;
    repeat (OS / 2) @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    chk("midrst_data_out", 32'(data_out), 32'd0);
    chk("midrst_parity", 32'(parity_bit_out), 32'd0);
    chk("midrst_valid", 32'(data_valid), 32'd0);
    chk("midrst_ferr", 32'(framing_error), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2 * OS) @(negedge clk);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    drive_bit(1'b1, 1'b0);

    // back-to-back frames, tick every 4 clks
    div = 4;
    drive_bit(1'b1, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, -1);
    drive_bit(1'b1, 1'b0);

`ifdef RX_MAJORITY_EN
    // single-clock glitch right at the bit-2 sample point must be voted out
    div = 1;
    drive_bit(1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    drive_bit(1'b1, 1'b0);
`endif

    // randomized frames
    for (int k = 0; k < 24; k++) begin
      div = $urandom_range(1, 4);
      d   = 8'($urandom);
      pe  = 1'($urandom_range(0, 1));
      pb  = 1'($urandom_range(0, 1));
      st  = ($urandom_range(0, 4) != 0);
      tg  = 1'($urandom_range(0, 1));
      drive_bit(1'b1, 1'b0);
      send_frame(d, pe, pb, st, tg, -1);
      if (!st) begin
        repeat ($urandom_range(0, 3 * OS) * div) @(negedge clk);
        drive_bit(1'b1, 1'b0);
      end
      repeat ($urandom_range(0, 2)) drive_bit(1'b1, 1'b0);
    end

    repeat (4 * OS * div) @(negedge clk);
    chk("all_frames_seen", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, misc);
    $finish;
  end

endmodule
